bcd_serial_subtractor: RTL

//  Digit-serial multi-digit BCD subtractor; the reverse operation to the team's 4-bit BCD adder.

---
 rtl/bcd_serial_subtractor.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/bcd_serial_subtractor.sv
// bcd_serial_subtractor
//   Digit-serial packed-BCD subtractor, diff = a - b - b_in, one digit per
//   clock, least significant digit first. It is the companion of the BCD
//   adder in the arithmetic datapath. A start/busy/done handshake lets a
//   controller sequence adds and subtracts.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for start; diff/b_out/err hold the last result
//   RUN   | one digit per edge, digit index 0..DIGITS-1
//   DONE  | one cycle, done=1, result valid; back to IDLE next edge
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   synchronous reset, active low
//   start  in   request, accepted only in IDLE
//   a      in   minuend, packed BCD, digit 0 = bits [3:0]
//   b      in   subtrahend, packed BCD
//   b_in   in   borrow in
//   busy   out  high in RUN and DONE
//   done   out  one-cycle result-valid pulse
//   diff   out  BCD result (ten's complement when b_out=1)
//   b_out  out  borrow out, result negative
//   err    out  an operand digit was greater than 9
//
// Every output comes straight from a flop, so no path from the inputs
// reaches the outputs without a clock edge.

module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                b_in,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] diff,
  output logic                b_out,
  output logic                err
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,    state_d;
  logic [IDX_W-1:0] idx_q,      idx_d;
  logic [W-1:0]     a_sh_q,     a_sh_d;
  logic [W-1:0]     b_sh_q,     b_sh_d;
  logic             borrow_q,   borrow_d;
  logic             err_pend_q, err_pend_d;
  logic [W-1:0]     diff_q,     diff_d;
  logic             b_out_q,    b_out_d;
  logic             err_q,      err_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;

  logic signed [5:0] t_raw;
  logic signed [5:0] t_adj;
  logic [3:0]        dig;
  logic              borrow_nxt;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Digit slice. The operand copies shift right by one digit per edge, so
  // the digit being processed is always in bits [3:0].
  always_comb begin
    t_raw = $signed({2'b00, a_sh_q[3:0]})
          - $signed({2'b00, b_sh_q[3:0]})
          - $signed({5'b00000, borrow_q});
    t_adj = t_raw + 6'sd10;
    if (t_raw < 0) begin
      dig        = t_adj[3:0];
      borrow_nxt = 1'b1;
    end else begin
      dig        = t_raw[3:0];
      borrow_nxt = 1'b0;
    end
    // An invalid operand makes every digit meaningless; write zeros so the
    // diff bus never carries a non-BCD nibble, even while running.
    if (err_pend_q) dig = 4'd0;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    borrow_d   = borrow_q;
    err_pend_d = err_pend_q;
    diff_d     = diff_q;
    b_out_d    = b_out_q;
    err_d      = err_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d     = a;
          b_sh_d     = b;
          borrow_d   = b_in;
          err_pend_d = has_bad_digit(a) | has_bad_digit(b);
          diff_d     = '0;
          err_d      = 1'b0;
          idx_d      = '0;
          busy_d     = 1'b1;
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        for (int j = 0; j < DIGITS; j++) begin
          if (idx_q == IDX_W'(j)) diff_d[4*j +: 4] = dig;
        end
        a_sh_d   = a_sh_q >> 4;
        b_sh_d   = b_sh_q >> 4;
        borrow_d = borrow_nxt;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_DONE;
          done_d  = 1'b1;
          if (err_pend_q) begin
            err_d   = 1'b1;
            diff_d  = '0;
            b_out_d = 1'b0;
          end else begin
            b_out_d = borrow_nxt;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      borrow_q   <= 1'b0;
      err_pend_q <= 1'b0;
      diff_q     <= '0;
      b_out_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      borrow_q   <= borrow_d;
      err_pend_q <= err_pend_d;
      diff_q     <= diff_d;
      b_out_q    <= b_out_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign diff  = diff_q;
  assign b_out = b_out_q;
  assign err   = err_q;

endmodule
